// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding, CR/LF byte constants and default tx_done timeout for the echo path.
// The LF_START/LF_WAIT states exist only when CRLF_EXPAND_EN is defined.
package uart_pkg;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam int TIMEOUT_CYC_DEF = 200000;
`ifdef CRLF_EXPAND_EN
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, LF_START, LF_WAIT} state_e;
`else
    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;
`endif
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and a registered occupancy count.
// A push while full is accepted when a pop lands on the same edge.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q, wr_d, rd_d, count_q;
    logic do_push, do_pop;

    assign empty_o = wr_q == rd_q;
    assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o = mem_q[rd_q[AW-1:0]];
    assign count_o = count_q;

    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= wr_d - rd_d;
        end
endmodule

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffers UART rx bytes and replays them to the transmitter with a start/done handshake.
// Define CRLF_EXPAND_EN to follow every transmitted 0x0D with an extra 0x0A frame.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [AW:0] fifo_count,
    output logic        overflow,
    output logic        timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e state_q;
    logic tx_start_q, overflow_q, timeout_q;
    logic [7:0] tx_data_q;
    logic [TW-1:0] timer_q;
    logic [7:0] fifo_dout;
    logic full, empty, pop;

    assign pop = state_q == LOAD;
    assign tx_start = tx_start_q;
    assign tx_data = tx_data_q;
    assign overflow = overflow_q;
    assign timeout = timeout_q;

    sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(rx_done),
        .pop_i(pop),
        .din_i(rx_data),
        .dout_o(fifo_dout),
        .full_o(full),
        .empty_o(empty),
        .count_o(fifo_count)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q <= 8'h00;
            timer_q <= '0;
            overflow_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            if (rx_done && full && !pop) overflow_q <= 1'b1;
            case (state_q)
                IDLE: if (!empty) state_q <= LOAD;
                LOAD: begin
                    tx_data_q <= fifo_dout;
                    tx_start_q <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
`ifdef CRLF_EXPAND_EN
                LF_START: begin
                    timer_q <= '0;
                    state_q <= LF_WAIT;
                end
                WAIT, LF_WAIT:
`else
                WAIT:
`endif
                    if (tx_done) begin
`ifdef CRLF_EXPAND_EN
                        if (state_q == WAIT && tx_data_q == CR) begin
                            tx_data_q <= LF;
                            tx_start_q <= 1'b1;
                            state_q <= LF_START;
                        end else
`endif
                        state_q <= IDLE;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        // frame abandoned; move on to the next buffered byte
                        timeout_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed self-checking bench for uart_echo_fifo (DEPTH=16, TIMEOUT_CYC=50).
// Honours CRLF_EXPAND_EN for the CR expansion step.
module tb_uart_echo_fifo;
    logic clk = 1'b0, rst = 1'b0, rx_done = 1'b0, tx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic tx_start, overflow, timeout;
    logic [7:0] tx_data;
    logic [4:0] fifo_count;
    int ncmp = 0, nerr = 0, cyc = 0, b;
    logic [7:0] sq[$];
    int sc[$];

    uart_echo_fifo #(.DEPTH(16), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
        .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_start) begin sq.push_back(tx_data); sc.push_back(cyc); end

    task automatic tick; @(posedge clk); #1; endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rx(input logic [7:0] d); rx_data = d; rx_done = 1'b1; tick; rx_done = 1'b0; endtask
    task automatic done; tx_done = 1'b1; tick; tx_done = 1'b0; endtask
    task automatic do_reset; rst = 1'b0; tick; tick; rst = 1'b1; endtask

    task automatic wait_starts(input int n);
        for (int k = 0; k < 200 && sq.size() < n; k++) tick;
        chk("start_seen", 32'(sq.size() >= n), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rx_done = 1'b1; rx_data = 8'hAA;
        tick; tick; tick;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        rx_done = 1'b0; rst = 1'b1;
        tick; tick;
        chk("rst_no_push", fifo_count, 0);
        chk("rst_no_start", sq.size(), 0);

        rx(8'h41);
        chk("single_count", fifo_count, 1);
        chk("single_start_n0", tx_start, 0);
        tick;
        chk("single_start_n1", tx_start, 0);
        tick;
        chk("single_start_n2", tx_start, 1);
        chk("single_data", tx_data, 8'h41);
        chk("single_count_pop", fifo_count, 0);
        tick;
        chk("single_pulse_width", tx_start, 0);
        repeat (10) tick;
        chk("single_hold", tx_data, 8'h41);
        done;
        repeat (5) tick;
        chk("single_frames", sq.size(), 1);
        chk("single_timeout", timeout, 0);

        b = sq.size();
        for (int i = 0; i < 5; i++) rx(8'h31 + 8'(i));
        chk("burst_peak", fifo_count, 4);
        for (int i = 0; i < 5; i++) begin
            wait_starts(b + i + 1);
            while (cyc < sc[b+i] + 20) tick;
            done;
        end
        repeat (5) tick;
        chk("burst_frames", sq.size(), b + 5);
        for (int i = 0; i < 5; i++) chk("burst_order", sq[b+i], 8'h31 + 8'(i));
        chk("burst_count", fifo_count, 0);
        chk("burst_timeout", timeout, 0);

        do_reset;
        b = sq.size();
        for (int i = 0; i < 17; i++) rx(8'h50 + 8'(i));
        chk("fill17_count", fifo_count, 16);
        chk("fill17_overflow", overflow, 0);
        rx(8'h7F);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", fifo_count, 16);
        wait_starts(b + 1);
        chk("ovf_first", sq[b], 8'h50);
        while (cyc < sc[b] + 50) tick;
        chk("timeout_before", timeout, 0);
        tick;
        chk("timeout_set", timeout, 1);
        wait_starts(b + 2);
        chk("timeout_next_byte", sq[b+1], 8'h51);
        chk("timeout_next_gap", sc[b+1] - sc[b], 53);
        chk("ovf_sticky", overflow, 1);
        chk("timeout_count", fifo_count, 15);

        do_reset;
        b = sq.size();
        chk("rst_clears_timeout", timeout, 0);
        for (int i = 0; i < 17; i++) rx(8'h60 + 8'(i));
        chk("full_count", fifo_count, 16);
        done;
        tick;
        rx(8'h90);
        chk("pushpop_count", fifo_count, 16);
        chk("pushpop_overflow", overflow, 0);
        chk("pushpop_start", tx_start, 1);
        chk("pushpop_data", tx_data, 8'h61);
        rx(8'h91);
        chk("full_drop_overflow", overflow, 1);
        chk("full_drop_count", fifo_count, 16);
        done;
        tick; tick;
        chk("midframe_start", tx_start, 1);
        chk("midframe_data", tx_data, 8'h62);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_start", tx_start, 0);
        chk("async_rst_data", tx_data, 8'h00);
        chk("async_rst_count", fifo_count, 0);
        chk("async_rst_overflow", overflow, 0);

        do_reset;
        b = sq.size();
        rx(8'h0D);
        wait_starts(b + 1);
        chk("cr_frame", sq[b], 8'h0D);
        done;
`ifdef CRLF_EXPAND_EN
        wait_starts(b + 2);
        chk("lf_frame", sq[b+1], 8'h0A);
        chk("lf_count", fifo_count, 0);
        done;
        repeat (10) tick;
        chk("crlf_frames", sq.size(), b + 2);
`else
        repeat (10) tick;
        chk("cr_only_frames", sq.size(), b + 1);
`endif
        chk("cr_count", fifo_count, 0);
        chk("cr_timeout", timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
